// File: rtl/tag_ctrl_pkg.sv
// Shared constants, tag-entry layout and controller state encoding for the
// tag SRAM controller and its way-compare helper.
package tag_ctrl_pkg;

  localparam int SETS    = 64;
  localparam int WAYS    = 8;
  localparam int ENTRY_W = 23;
  localparam int TAG_W   = 22;
  localparam int ADDR_W  = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int ROW_W   = WAYS * ENTRY_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [2:0] {
    S_INIT_A = 3'd0,
    S_INIT_D = 3'd1,
    S_IDLE   = 3'd2,
    S_RD_CMP = 3'd3,
    S_RESP   = 3'd4,
    S_FILL_A = 3'd5,
    S_FILL_D = 3'd6
  } state_t;

endpackage

// File: rtl/tag_array_ctrl_match.sv
// Combinational 8-way tag compare: per-way match, lowest-index priority
// encode, valid-bit extraction and multiple-match detection.
module tag_match
  import tag_ctrl_pkg::*;
(
  input  logic [ROW_W-1:0] i_row,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_hit,
  output logic [WAY_W-1:0] o_way,
  output logic [WAYS-1:0]  o_valid_ways,
  output logic             o_multi_hit
);

  tag_entry_t       w_entry;
  logic [WAYS-1:0]  w_match;
  logic [WAY_W:0]   w_cnt;

  always_comb begin
    w_entry      = '0;
    w_match      = '0;
    o_valid_ways = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_entry         = tag_entry_t'(i_row[w*ENTRY_W +: ENTRY_W]);
      o_valid_ways[w] = w_entry.valid;
      w_match[w]      = w_entry.valid && (w_entry.tag == i_tag);
    end
  end

  // Scan from the top so the lowest matching way wins.
  always_comb begin
    o_way = '0;
    w_cnt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) begin
        o_way = WAY_W'(w);
        w_cnt = w_cnt + (WAY_W+1)'(1);
      end
    end
    o_hit       = |w_match;
    o_multi_hit = (w_cnt > (WAY_W+1)'(1));
  end

endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM initiator: clears all sets after reset, then serves lookups and
// fills/invalidates one SRAM operation at a time (fills take priority).
module tag_array_ctrl
  import tag_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_set,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [WAYS-1:0]   resp_valid_ways,
  output logic              resp_multi_hit,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_set,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              fill_inval,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [ROW_W-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [ROW_W-1:0]  W0_data,
  output logic [WAYS-1:0]   W0_mask
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_set_cnt;
  logic              r_init_done;
  logic [TAG_W-1:0]  r_lk_tag;
  logic [ADDR_W-1:0] r_fill_set;
  logic [WAY_W-1:0]  r_fill_way;
  tag_entry_t        r_fill_entry;
  logic              r_resp_valid;
  logic              r_resp_hit;
  logic [WAY_W-1:0]  r_resp_way;
  logic [WAYS-1:0]   r_resp_vw;
  logic              r_resp_multi;
  logic              w_lk_acc;
  logic              w_fill_acc;
  logic              w_hit;
  logic [WAY_W-1:0]  w_way;
  logic [WAYS-1:0]   w_vw;
  logic              w_multi;

  tag_match u_match (
    .i_row        (R0_data),
    .i_tag        (r_lk_tag),
    .o_hit        (w_hit),
    .o_way        (w_way),
    .o_valid_ways (w_vw),
    .o_multi_hit  (w_multi)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT_A;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT_A: w_next = S_INIT_D;
      S_INIT_D: w_next = (r_set_cnt == ADDR_W'(SETS - 1)) ? S_IDLE : S_INIT_A;
      S_IDLE: begin
        if (fill_valid)     w_next = S_FILL_A;
        else if (req_valid) w_next = S_RD_CMP;
      end
      S_RD_CMP: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      S_FILL_A: w_next = S_FILL_D;
      S_FILL_D: w_next = S_IDLE;
      default:  w_next = S_INIT_A;
    endcase
  end

  // SRAM port drive: address leads enable by one cycle on the write port.
  always_comb begin
    fill_ready = (r_state == S_IDLE);
    req_ready  = (r_state == S_IDLE) && !fill_valid;
    w_lk_acc   = req_ready && req_valid;
    w_fill_acc = fill_ready && fill_valid;
    R0_en      = w_lk_acc;
    R0_addr    = w_lk_acc ? req_set : '0;
    W0_addr    = '0;
    W0_en      = 1'b0;
    W0_mask    = '0;
    W0_data    = '0;
    unique case (r_state)
      S_INIT_A: W0_addr = r_set_cnt;
      S_INIT_D: begin
        W0_addr = r_set_cnt;
        W0_en   = 1'b1;
        W0_mask = '1;
      end
      S_FILL_A: W0_addr = r_fill_set;
      S_FILL_D: begin
        W0_addr = r_fill_set;
        W0_en   = 1'b1;
        W0_mask = WAYS'(1) << r_fill_way;
        W0_data = {WAYS{r_fill_entry}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_set_cnt    <= '0;
      r_init_done  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_resp_vw    <= '0;
      r_resp_multi <= 1'b0;
    end else begin
      if (r_state == S_INIT_D) begin
        r_set_cnt <= r_set_cnt + ADDR_W'(1);
        if (r_set_cnt == ADDR_W'(SETS - 1)) r_init_done <= 1'b1;
      end
      if (r_state == S_RD_CMP) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= w_hit;
        r_resp_way   <= w_way;
        r_resp_vw    <= w_vw;
        r_resp_multi <= w_multi;
      end else if (r_state == S_RESP && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Request payload latches; only consumed in states reached after an accept.
  always_ff @(posedge clock) begin
    if (w_lk_acc) r_lk_tag <= req_tag;
    if (w_fill_acc) begin
      r_fill_set         <= fill_set;
      r_fill_way         <= fill_way;
      r_fill_entry.valid <= ~fill_inval;
      r_fill_entry.tag   <= fill_inval ? '0 : fill_tag;
    end
  end

  assign init_done       = r_init_done;
  assign resp_valid      = r_resp_valid;
  assign resp_hit        = r_resp_hit;
  assign resp_way        = r_resp_way;
  assign resp_valid_ways = r_resp_vw;
  assign resp_multi_hit  = r_resp_multi;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Bench for tag_array_ctrl: SRAM model, per-way reference tag store and a
// response scoreboard drained by an independent monitor.
module tb_tag_array_ctrl;
  import tag_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_set = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic [WAYS-1:0]   resp_valid_ways;
  logic              resp_multi_hit;
  logic              fill_valid = 1'b0;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_set = '0;
  logic [WAY_W-1:0]  fill_way = '0;
  logic [TAG_W-1:0]  fill_tag = '0;
  logic              fill_inval = 1'b0;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [ROW_W-1:0]  R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [ROW_W-1:0]  W0_data;
  logic [WAYS-1:0]   W0_mask;

  tag_array_ctrl dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_valid_ways(resp_valid_ways), .resp_multi_hit(resp_multi_hit),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
    .fill_way(fill_way), .fill_tag(fill_tag), .fill_inval(fill_inval),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // SRAM model: registered read, per-lane masked write; starts full of ones.
  logic [ROW_W-1:0] mem [SETS];
  logic [ROW_W-1:0] r0_q = '0;
  assign R0_data = r0_q;
  initial for (int s = 0; s < SETS; s++) mem[s] = '1;
  always @(posedge clock) begin
    if (R0_en) r0_q <= mem[R0_addr];
    if (W0_en)
      for (int w = 0; w < WAYS; w++)
        if (W0_mask[w]) mem[W0_addr][w*ENTRY_W +: ENTRY_W] = W0_data[w*ENTRY_W +: ENTRY_W];
  end

  // Reference tag store
  logic             ref_v [SETS][WAYS];
  logic [TAG_W-1:0] ref_t [SETS][WAYS];

  task automatic ref_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        ref_v[s][w] = 1'b0;
        ref_t[s][w] = '0;
      end
  endtask

  typedef struct {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [WAYS-1:0]  vw;
    logic             multi;
    longint           acc;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t model(input int s, input logic [TAG_W-1:0] t, input longint acc);
    exp_t e;
    int   cnt = 0;
    e.way = '0;
    e.vw  = '0;
    for (int w = 0; w < WAYS; w++) begin
      e.vw[w] = ref_v[s][w];
      if (ref_v[s][w] && ref_t[s][w] == t) begin
        if (cnt == 0) e.way = WAY_W'(w);
        cnt++;
      end
    end
    e.hit   = (cnt > 0);
    e.multi = (cnt > 1);
    e.acc   = acc;
    return e;
  endfunction

  // Response monitor
  logic prev_rv = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) prev_rv = 1'b0;
    else begin
      if (resp_valid && !prev_rv) begin
        if (sb.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_latency", cyc - sb[0].acc, 2);
      end
      if (resp_valid && resp_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_way", resp_way, e.way);
        chk("resp_valid_ways", resp_valid_ways, e.vw);
        chk("resp_multi_hit", resp_multi_hit, e.multi);
      end
      prev_rv = resp_valid;
    end
  end

  // Write-port contract monitor
  logic              prev_wen = 1'b0;
  logic [ADDR_W-1:0] prev_waddr = '0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (W0_en) begin
        chk("w0_addr_setup", W0_addr, prev_waddr);
        chk("w0_en_gap", prev_wen, 0);
      end else begin
        chk("w0_mask_idle", W0_mask, 0);
      end
    end
    prev_wen   = W0_en;
    prev_waddr = W0_addr;
  end

  logic hold_rr = 1'b0;
  logic rand_rr = 1'b0;
  always @(posedge clock) begin
    #1;
    resp_ready = hold_rr ? 1'b0 : (rand_rr ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  task automatic init_sweep();
    for (int c = 0; c < 130; c++) begin
      @(negedge clock);
      if (c < 2 * SETS) begin
        chk("init_w0_en", W0_en, c % 2);
        chk("init_w0_addr", W0_addr, c / 2);
        if (c % 2 == 1) begin
          chk("init_w0_mask", W0_mask, 8'hFF);
          chk("init_w0_data", W0_data, 0);
        end
      end
      chk("init_done", init_done, c >= 2 * SETS);
      chk("init_fill_ready", fill_ready, c >= 2 * SETS);
      chk("init_req_ready", req_ready, c >= 2 * SETS);
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ref_clear();
    init_sweep();
  endtask

  task automatic lookup(input int s, input logic [TAG_W-1:0] t);
    int n = 0;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_set   = ADDR_W'(s);
    req_tag   = t;
    @(negedge clock);
    while (!req_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("req_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    chk("r0_en", R0_en, 1);
    chk("r0_addr", R0_addr, s);
    sb.push_back(model(s, t, cyc));
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic fill(input int s, input int w, input logic [TAG_W-1:0] t, input logic inv);
    logic [ROW_W-1:0] d;
    logic [WAYS-1:0]  m;
    int n = 0;
    for (int l = 0; l < WAYS; l++) d[l*ENTRY_W +: ENTRY_W] = inv ? '0 : {1'b1, t};
    m = WAYS'(1) << w;
    @(posedge clock);
    #1;
    fill_valid = 1'b1;
    fill_set   = ADDR_W'(s);
    fill_way   = WAY_W'(w);
    fill_tag   = t;
    fill_inval = inv;
    @(negedge clock);
    while (!fill_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!fill_ready) begin
      chk("fill_timeout", 0, 1);
      fill_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    fill_valid = 1'b0;
    @(negedge clock);
    chk("fill_a_en", W0_en, 0);
    chk("fill_a_addr", W0_addr, s);
    @(negedge clock);
    chk("fill_d_en", W0_en, 1);
    chk("fill_d_addr", W0_addr, s);
    chk("fill_d_mask", W0_mask, m);
    chk("fill_d_data", W0_data, d);
    ref_v[s][w] = !inv;
    ref_t[s][w] = inv ? '0 : t;
  endtask

  task automatic wait_resp_valid();
    int n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("resp_valid_seen", resp_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] snap;
    ref_clear();
    repeat (3) @(negedge clock);
    chk("rst_outputs", {init_done, req_ready, fill_ready, resp_valid, resp_hit, resp_way,
                        resp_valid_ways, resp_multi_hit, R0_en, R0_addr, W0_en, W0_addr}, 0);
    chk("rst_w0_data", W0_data, 0);
    chk("rst_w0_mask", W0_mask, 0);
    release_reset();

    fill(5, 3, 22'h12345, 1'b0);
    lookup(5, 22'h12345);
    lookup(5, 22'h12346);
    fill(5, 3, 22'h0, 1'b1);
    lookup(5, 22'h12345);
    fill(9, 1, 22'h3, 1'b0);
    fill(9, 6, 22'h3, 1'b0);
    lookup(9, 22'h3);
    drain();

    // Stalled response must hold steady and block new lookups
    hold_rr = 1'b1;
    lookup(9, 22'h3);
    wait_resp_valid();
    snap = {resp_hit, resp_way, resp_valid_ways};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_stable", {resp_hit, resp_way, resp_valid_ways}, snap);
      chk("stall_multi", resp_multi_hit, 1);
      chk("stall_valid", resp_valid, 1);
      chk("stall_req_ready", req_ready, 0);
    end
    hold_rr = 1'b0;
    drain();

    // Simultaneous fill and lookup: fill wins, lookup then sees the new entry
    @(posedge clock);
    #1;
    fill_valid = 1'b1; fill_set = 6'd20; fill_way = 3'd0; fill_tag = 22'h55; fill_inval = 1'b0;
    req_valid  = 1'b1; req_set  = 6'd20; req_tag  = 22'h55;
    @(negedge clock);
    chk("prio_fill_ready", fill_ready, 1);
    chk("prio_req_ready", req_ready, 0);
    chk("prio_r0_en", R0_en, 0);
    @(posedge clock);
    #1;
    fill_valid = 1'b0;
    @(negedge clock);
    chk("prio_fill_a_en", W0_en, 0);
    @(negedge clock);
    chk("prio_fill_d_en", W0_en, 1);
    chk("prio_fill_d_mask", W0_mask, 8'h01);
    ref_v[20][0] = 1'b1;
    ref_t[20][0] = 22'h55;
    @(negedge clock);
    chk("prio_req_ready_after", req_ready, 1);
    chk("prio_r0_en_after", R0_en, 1);
    sb.push_back(model(20, 22'h55, cyc));
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    drain();

    // Reset while a response is pending
    hold_rr = 1'b1;
    lookup(9, 22'h3);
    wait_resp_valid();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    sb.delete();
    hold_rr = 1'b0;
    release_reset();

    // Reset during FILL_A: the write must never happen
    @(posedge clock);
    #1;
    fill_valid = 1'b1; fill_set = 6'd12; fill_way = 3'd2; fill_tag = 22'h777; fill_inval = 1'b0;
    @(negedge clock);
    chk("rfill_ready", fill_ready, 1);
    @(posedge clock);
    #1;
    fill_valid = 1'b0;
    @(negedge clock);
    chk("rfill_a_en", W0_en, 0);
    chk("rfill_a_addr", W0_addr, 12);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rfill_no_write", W0_en, 0);
      chk("rfill_resp_valid", resp_valid, 0);
      chk("rfill_init_done", init_done, 0);
    end
    release_reset();
    lookup(9, 22'h3);
    lookup(12, 22'h777);
    drain();

    // Randomized traffic over a few sets with a small tag pool
    rand_rr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int s = $urandom_range(0, 3);
      int w = $urandom_range(0, 7);
      logic [TAG_W-1:0] t = TAG_W'($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) lookup(s, t);
      else fill(s, w, t, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 0) lookup(s, t);
    end
    rand_rr = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
